// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
// Command-side initiator for the pulse-triggered ALU. Takes commands on a
// valid/ready stream and drives one operation at a time onto the ALU pins.
// It waits for the one-cycle alu_done pulse and returns result, flags and tag
// on a valid/ready response stream. A watchdog turns a missing alu_done into
// a timeout response.
//
// Build option: define ALU_DRV_CMD_FIFO_EN to place a DEPTH-entry command
// FIFO in front of the FSM. Without it, commands are taken only in IDLE and
// loaded directly on the accept edge.

module alu_cmd_driver #(
   parameter int WIDTH          = 8,
   parameter int TAG_W          = 4,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   // command stream
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   // ALU pins
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_opcode,
   output logic             alu_execute,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags,
   input  logic             alu_done,
   // response stream
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_timeout,
   // status
   output logic             busy,
   output logic [7:0]       tmo_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0]       opcode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   // Wide enough to hold TIMEOUT_CYCLES, the value reached on the last WAIT cycle.
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   // Elaboration-time parameter sanity checks.
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("alu_cmd_driver: TIMEOUT_CYCLES must be at least 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("alu_cmd_driver: DEPTH must be a power of two and at least 2");
   end

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             tmo_hit;
   logic             load;         // FSM takes a command this cycle (IDLE only)
   logic             out_of_reset; // keeps cmd_ready low while rst is applied
   cmd_t             in_cmd;
   cmd_t             load_cmd;

   assign in_cmd  = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, tag: cmd_tag};
   assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Goes high on the first edge that samples rst low and gates cmd_ready.
   // NOTE: every clocked process uses non-blocking assignments so that all
   // registers sample pre-edge values regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (rst) out_of_reset <= 1'b0;
      else     out_of_reset <= 1'b1;
   end

`ifdef ALU_DRV_CMD_FIFO_EN
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   cmd_t             fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic             idle_hold; // one settling IDLE cycle after each response

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign cmd_ready = out_of_reset & ~full;
   assign push      = cmd_valid & cmd_ready;
   assign load      = (state == S_IDLE) & ~empty & ~idle_hold;
   assign pop       = load;
   assign load_cmd  = fifo_mem[rd_ptr];

   // Command storage: written on push only.
   // NOTE: storage is deliberately not reset; the registered count guarantees
   // no entry is read before it has been written.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= in_cmd;
   end

   // Pointers and occupancy count; push and pop may coincide when not full.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Holds off the pop for one cycle after a response handshake, which sets
   // the queued-command cadence to one operation every five cycles.
   always_ff @(posedge clk) begin
      if (rst) idle_hold <= 1'b0;
      else     idle_hold <= (state == S_RESP) & rsp_ready;
   end
`else
   assign cmd_ready = out_of_reset & (state == S_IDLE);
   assign load      = cmd_valid & cmd_ready;
   assign load_cmd  = in_cmd;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state logic; alu_done is only looked at in WAIT.
   // NOTE: state_nxt gets a default before the case so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (load) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (alu_done || tmo_hit) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs, decoded straight from the state register.
   always_comb begin
      alu_execute = (state == S_ISSUE);
      rsp_valid   = (state == S_RESP);
      busy        = (state != S_IDLE);
   end

   // Watchdog: counts WAIT cycles, cleared while the execute pulse is out.
   always_ff @(posedge clk) begin
      if (rst)                   wait_cnt <= '0;
      else if (state == S_ISSUE) wait_cnt <= '0;
      else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
   end

   // Operand, opcode and tag registers: written only on a load in IDLE, so
   // they are stable through ISSUE, WAIT and RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_tag    <= '0;
      end else if (load) begin
         alu_a      <= load_cmd.a;
         alu_b      <= load_cmd.b;
         alu_opcode <= load_cmd.opcode;
         rsp_tag    <= load_cmd.tag;
      end
   end

   // Response capture in WAIT: a done pulse wins over a coincident timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_result  <= '0;
         rsp_flags   <= '0;
         rsp_timeout <= 1'b0;
         tmo_count   <= '0;
      end else if (state == S_WAIT) begin
         if (alu_done) begin
            rsp_result  <= alu_result;
            rsp_flags   <= alu_flags;
            rsp_timeout <= 1'b0;
         end else if (tmo_hit) begin
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b1;
            if (tmo_count != 8'hFF) tmo_count <= tmo_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed testbench for alu_cmd_driver with a small pulse-triggered ALU model
// (ADD/SUB, flags {Z,N,C,V}) that answers one cycle after each execute edge.
// Define ALU_DRV_CMD_FIFO_EN for both files to exercise the FIFO build.

module tb_alu_cmd_driver;
   localparam int WIDTH = 8;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;
`ifdef ALU_DRV_CMD_FIFO_EN
   localparam int ISS_OFS = 2;
   localparam int PERIOD  = 5;
`else
   localparam int ISS_OFS = 1;
   localparam int PERIOD  = 4;
`endif
   localparam int RSP_OFS = ISS_OFS + 2;

   logic             clk        = 1'b0;
   logic             rst        = 1'b1;
   logic             cmd_valid  = 1'b0;
   logic [3:0]       cmd_opcode = '0;
   logic [WIDTH-1:0] cmd_a      = '0;
   logic [WIDTH-1:0] cmd_b      = '0;
   logic [TAG_W-1:0] cmd_tag    = '0;
   logic             rsp_ready  = 1'b0;
   logic             cmd_ready;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [3:0]       alu_opcode;
   logic             alu_execute;
   logic [WIDTH-1:0] alu_result = '0;
   logic [3:0]       alu_flags  = '0;
   logic             alu_done;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_timeout;
   logic             busy;
   logic [7:0]       tmo_count;

   logic model_done = 1'b0;
   logic inj_done   = 1'b0;
   logic alu_en     = 1'b1;
   logic exec_q     = 1'b0;
   assign alu_done = model_done | inj_done;

   int n_vec   = 0;
   int n_err   = 0;
   int cyc     = 0;
   int low_run = 1000;
   int min_gap = 1000;
   int exec_cyc[$];

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] res;
      logic [3:0]       fl;
      logic             tmo;
   } rsp_t;
   rsp_t rsp_q[$];

   logic [3:0]       s_op  [8];
   logic [WIDTH-1:0] s_a   [8];
   logic [WIDTH-1:0] s_b   [8];
   logic [TAG_W-1:0] s_tag [8];

   alu_cmd_driver #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_execute(alu_execute),
      .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
      .busy(busy), .tmo_count(tmo_count)
   );

   always #5 clk = ~clk;

   // ALU behaviour: returns {flags, result}; opcode 0 = ADD, 1 = SUB, else AND.
   function automatic logic [WIDTH+3:0] alu_fn(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH:0]   s;
      logic [WIDTH-1:0] r;
      logic             c, v;
      case (op)
         4'h0: begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
         end
         4'h1: begin
            s = {1'b0, a} + {1'b0, ~b} + 1'b1;
            v = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
         end
         default: begin
            s = {1'b0, a & b};
            v = 1'b0;
         end
      endcase
      r = s[WIDTH-1:0];
      c = s[WIDTH];
      return {(r == '0), r[WIDTH-1], c, v, r};
   endfunction

   // ALU model: done one cycle after each execute rising edge; logs pulses and gaps.
   always @(posedge clk) begin
      cyc        <= cyc + 1;
      model_done <= 1'b0;
      if (alu_execute === 1'b1 && exec_q === 1'b0) begin
         exec_cyc.push_back(cyc);
         if (low_run < min_gap) min_gap <= low_run;
         low_run <= 0;
         if (alu_en) begin
            {alu_flags, alu_result} <= alu_fn(alu_opcode, alu_a, alu_b);
            model_done <= 1'b1;
         end
      end else if (alu_execute === 1'b0) begin
         low_run <= low_run + 1;
      end
      exec_q <= alu_execute;
   end

   // Response monitor: records every completed response handshake.
   always @(posedge clk) begin
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && rst === 1'b0)
         rsp_q.push_back('{rsp_tag, rsp_result, rsp_flags, rsp_timeout});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, expected end before 200000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [3:0] op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_tag    = tag;
   endtask

   // One command with exact-latency checks; expects an idle DUT and a live ALU.
   task automatic do_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp_res,
                        input logic [3:0] exp_fl, input string name);
      int e0 = exec_cyc.size();
      rsp_ready = 1'b1;
      drive_cmd(op, a, b, tag);
      n_vec++;
      if (cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL %s_ready: got %b, expected 1", name, cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= RSP_OFS; k++) begin
         n_vec++;
         if ({alu_execute, rsp_valid} !== {1'(k == ISS_OFS), 1'(k == RSP_OFS)}) begin
            n_err++;
            $display("FAIL %s_timing c+%0d: got exec/valid %b%b, expected %b%b", name, k,
                     alu_execute, rsp_valid, 1'(k == ISS_OFS), 1'(k == RSP_OFS));
         end
         if (k < RSP_OFS) tick();
      end
      n_vec++;
      if ({rsp_result, rsp_flags, rsp_tag, rsp_timeout} !== {exp_res, exp_fl, tag, 1'b0}) begin
         n_err++;
         $display("FAIL %s_rsp: got res %h flags %h tag %h tmo %b, expected res %h flags %h tag %h tmo 0",
                  name, rsp_result, rsp_flags, rsp_tag, rsp_timeout, exp_res, exp_fl, tag);
      end
      n_vec++;
      if ({alu_opcode, alu_a, alu_b} !== {op, a, b}) begin
         n_err++;
         $display("FAIL %s_pins: got %h/%h/%h, expected %h/%h/%h", name, alu_opcode, alu_a, alu_b, op, a, b);
      end
      tick();
      n_vec++;
      if ({rsp_valid, busy} !== 2'b00) begin
         n_err++; $display("FAIL %s_done: got valid/busy %b%b, expected 00", name, rsp_valid, busy);
      end
      n_vec++;
      if (exec_cyc.size() - e0 != 1) begin
         n_err++; $display("FAIL %s_pulses: got %0d, expected 1", name, exec_cyc.size() - e0);
      end
   endtask

   // Streams s_* entries 0..n-1 with cmd_valid held; bounded by a cycle budget.
   task automatic send_stream(input int n, input string name);
      int   idx = 0;
      int   guard = 0;
      logic rdy;
      drive_cmd(s_op[0], s_a[0], s_b[0], s_tag[0]);
      while (idx < n && guard < 100) begin
         rdy = cmd_ready;
         tick();
         guard++;
         if (rdy === 1'b1) begin
            idx++;
            if (idx < n) drive_cmd(s_op[idx], s_a[idx], s_b[idx], s_tag[idx]);
         end
      end
      cmd_valid = 1'b0;
      n_vec++;
      if (idx != n) begin
         n_err++; $display("FAIL %s_accept: got %0d accepted, expected %0d", name, idx, n);
      end
   endtask

   task automatic wait_rsp(input int target, input string name);
      int guard = 0;
      while (rsp_q.size() < target && guard < 200) begin
         tick();
         guard++;
      end
      n_vec++;
      if (rsp_q.size() != target) begin
         n_err++; $display("FAIL %s_rsp_count: got %0d, expected %0d", name, rsp_q.size(), target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; inj_done = 1'b0; alu_en = 1'b1;
      repeat (3) tick();
      n_vec++;
      if ({cmd_ready, busy, alu_execute, rsp_valid} !== 4'b0000) begin
         n_err++; $display("FAIL reset_ctrl: got %b, expected 0000", {cmd_ready, busy, alu_execute, rsp_valid});
      end
      n_vec++;
      if ({alu_opcode, alu_a, alu_b} !== '0) begin
         n_err++; $display("FAIL reset_alu_pins: got %h, expected 0", {alu_opcode, alu_a, alu_b});
      end
      n_vec++;
      if ({rsp_result, rsp_flags, rsp_tag, rsp_timeout} !== '0) begin
         n_err++; $display("FAIL reset_rsp: got %h, expected 0", {rsp_result, rsp_flags, rsp_tag, rsp_timeout});
      end
      n_vec++;
      if (tmo_count !== 8'h00) begin
         n_err++; $display("FAIL reset_tmo_count: got %h, expected 00", tmo_count);
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_err++; $display("FAIL reset_release: got ready/busy %b%b, expected 10", cmd_ready, busy);
      end
   endtask

   task automatic test_add();
      do_op(4'h0, 8'h05, 8'h03, 4'h7, 8'h08, 4'h0, "add");
   endtask

   task automatic test_carry();
      do_op(4'h0, 8'hFF, 8'h01, 4'h2, 8'h00, 4'hA, "carry");
   endtask

   task automatic test_timeout();
      alu_en = 1'b0;
      rsp_ready = 1'b0;
      drive_cmd(4'h0, 8'h10, 8'h20, 4'h5);
      tick();
      cmd_valid = 1'b0;
      repeat (ISS_OFS - 1) tick();
      n_vec++;
      if (alu_execute !== 1'b1) begin
         n_err++; $display("FAIL tmo_issue: got exec %b, expected 1", alu_execute);
      end
      repeat (TMO) tick();
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL tmo_early: got valid %b at ISSUE+%0d, expected 0", rsp_valid, TMO);
      end
      tick();
      n_vec++;
      if (rsp_valid !== 1'b1) begin
         n_err++; $display("FAIL tmo_valid: got valid %b at ISSUE+%0d, expected 1", rsp_valid, TMO + 1);
      end
      n_vec++;
      if ({rsp_result, rsp_flags, rsp_tag, rsp_timeout, tmo_count} !== {8'h00, 4'h0, 4'h5, 1'b1, 8'h01}) begin
         n_err++;
         $display("FAIL tmo_rsp: got res %h flags %h tag %h tmo %b count %h, expected 00 0 5 1 01",
                  rsp_result, rsp_flags, rsp_tag, rsp_timeout, tmo_count);
      end
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      tick();
      n_vec++;
      if ({rsp_valid, rsp_result, rsp_flags, rsp_timeout, tmo_count, alu_execute, alu_a} !==
          {1'b1, 8'h00, 4'h0, 1'b1, 8'h01, 1'b0, 8'h10}) begin
         n_err++;
         $display("FAIL tmo_late_done: got valid %b res %h flags %h tmo %b count %h exec %b a %h, expected 1 00 0 1 01 0 10",
                  rsp_valid, rsp_result, rsp_flags, rsp_timeout, tmo_count, alu_execute, alu_a);
      end
      rsp_ready = 1'b1;
      tick();
      n_vec++;
      if ({rsp_valid, busy} !== 2'b00) begin
         n_err++; $display("FAIL tmo_release: got valid/busy %b%b, expected 00", rsp_valid, busy);
      end
      alu_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] exp_res [3] = '{8'h20, 8'h80, 8'h00};
      logic [3:0]       exp_fl  [3] = '{4'h2, 4'h5, 4'hB};
      int q0 = rsp_q.size();
      int e0 = exec_cyc.size();
      rsp_t r;
      s_op[0] = 4'h1; s_a[0] = 8'h30; s_b[0] = 8'h10; s_tag[0] = 4'h1;
      s_op[1] = 4'h0; s_a[1] = 8'h7F; s_b[1] = 8'h01; s_tag[1] = 4'h2;
      s_op[2] = 4'h0; s_a[2] = 8'h80; s_b[2] = 8'h80; s_tag[2] = 4'h3;
      rsp_ready = 1'b1;
      send_stream(3, "b2b");
      wait_rsp(q0 + 3, "b2b");
      for (int i = 0; i < 3 && q0 + i < rsp_q.size(); i++) begin
         r = rsp_q[q0 + i];
         n_vec++;
         if ({r.tag, r.res, r.fl, r.tmo} !== {s_tag[i], exp_res[i], exp_fl[i], 1'b0}) begin
            n_err++;
            $display("FAIL b2b_rsp%0d: got tag %h res %h flags %h tmo %b, expected tag %h res %h flags %h tmo 0",
                     i, r.tag, r.res, r.fl, r.tmo, s_tag[i], exp_res[i], exp_fl[i]);
         end
      end
      n_vec++;
      if (exec_cyc.size() - e0 != 3) begin
         n_err++; $display("FAIL b2b_pulses: got %0d, expected 3", exec_cyc.size() - e0);
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_vec++;
            if (exec_cyc[e0 + i] - exec_cyc[e0 + i - 1] != PERIOD) begin
               n_err++;
               $display("FAIL b2b_period%0d: got %0d cycles, expected %0d", i,
                        exec_cyc[e0 + i] - exec_cyc[e0 + i - 1], PERIOD);
            end
         end
      end
      n_vec++;
      if (min_gap < 3) begin
         n_err++; $display("FAIL b2b_exec_gap: got %0d low cycles, expected >= 3", min_gap);
      end
   endtask

   task automatic test_reset_mid();
      int q0 = rsp_q.size();
      alu_en = 1'b0;
      rsp_ready = 1'b1;
      drive_cmd(4'h0, 8'h01, 8'h01, 4'h9);
      tick();
      cmd_valid = 1'b0;
      repeat (ISS_OFS + 2) tick();
      n_vec++;
      if ({busy, rsp_valid, alu_execute} !== 3'b100) begin
         n_err++; $display("FAIL rstmid_wait: got busy/valid/exec %b%b%b, expected 100", busy, rsp_valid, alu_execute);
      end
      rst = 1'b1;
      tick();
      n_vec++;
      if ({cmd_ready, busy, alu_execute, rsp_valid, alu_opcode, alu_a, alu_b,
           rsp_result, rsp_flags, rsp_tag, rsp_timeout, tmo_count} !== '0) begin
         n_err++;
         $display("FAIL rstmid_outputs: got ready %b busy %b exec %b valid %b op %h a %h b %h res %h flags %h tag %h tmo %b count %h, expected all 0",
                  cmd_ready, busy, alu_execute, rsp_valid, alu_opcode, alu_a, alu_b,
                  rsp_result, rsp_flags, rsp_tag, rsp_timeout, tmo_count);
      end
      rst = 1'b0;
      alu_en = 1'b1;
      tick();
      repeat (TMO + 4) tick();
      n_vec++;
      if (rsp_q.size() != q0 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL rstmid_discard: got %0d responses valid %b, expected 0 responses valid 0",
                           rsp_q.size() - q0, rsp_valid);
      end
      do_op(4'h1, 8'h09, 8'h04, 4'h3, 8'h05, 4'h2, "sub_after_reset");
   endtask

`ifdef ALU_DRV_CMD_FIFO_EN
   task automatic test_fifo();
      int q0 = rsp_q.size();
      int e0 = exec_cyc.size();
      rsp_t r;
      for (int i = 0; i < 5; i++) begin
         s_op[i] = 4'h0; s_a[i] = 8'(i); s_b[i] = 8'h10; s_tag[i] = 4'(i);
      end
      rsp_ready = 1'b0;
      send_stream(5, "fifo");
      repeat (3) tick();
      n_vec++;
      if ({cmd_ready, rsp_valid, rsp_tag} !== {1'b0, 1'b1, 4'h0}) begin
         n_err++; $display("FAIL fifo_full: got ready %b valid %b tag %h, expected 0 1 0", cmd_ready, rsp_valid, rsp_tag);
      end
      rsp_ready = 1'b1;
      wait_rsp(q0 + 5, "fifo");
      for (int i = 0; i < 5 && q0 + i < rsp_q.size(); i++) begin
         r = rsp_q[q0 + i];
         n_vec++;
         if ({r.tag, r.res, r.fl, r.tmo} !== {4'(i), 8'(8'h10 + i), 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL fifo_rsp%0d: got tag %h res %h flags %h tmo %b, expected tag %h res %h flags 0 tmo 0",
                     i, r.tag, r.res, r.fl, r.tmo, 4'(i), 8'(8'h10 + i));
         end
      end
      n_vec++;
      if (exec_cyc.size() - e0 != 5) begin
         n_err++; $display("FAIL fifo_pulses: got %0d, expected 5", exec_cyc.size() - e0);
      end
      n_vec++;
      if (min_gap < 3) begin
         n_err++; $display("FAIL fifo_exec_gap: got %0d low cycles, expected >= 3", min_gap);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_carry();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
`ifdef ALU_DRV_CMD_FIFO_EN
      test_fifo();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
